mem_read_arbiter: RTL and testbench

MEM_READ_ARBITER -- requirements
Module: mem_read_arbiter

---
 rtl/mem_read_arbiter_pkg.sv | 38 +++
 rtl/mem_read_arb_select.sv | 34 +++
 rtl/mem_read_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_mem_read_arbiter.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_read_arbiter_pkg.sv
// Shared definitions for the memory read arbiter: requester indices, FSM states,
// bus widths and the ARID values each requester places on its read channel.
package mem_read_arbiter_pkg;

  localparam int NUM_READ_MASTERS = 3;
  localparam int ADDR_WIDTH       = 32;
  localparam int DATA_WIDTH       = 32;
  localparam int ID_WIDTH         = 4;

  typedef enum logic [1:0] {
    ARB_DC = 2'd0,
    ARB_IC = 2'd1,
    ARB_SB = 2'd2
  } arb_master_e;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_ADDR = 2'd1,
    ARB_DATA = 2'd2
  } arb_state_e;

  localparam logic [ID_WIDTH-1:0] ARID_DC = 4'd1;
  localparam logic [ID_WIDTH-1:0] ARID_IC = 4'd0;
  localparam logic [ID_WIDTH-1:0] ARID_SB = 4'd2;

  // Converts a one-hot grant vector into the requester index it selects.
  function automatic logic [1:0] grant_to_index(input logic [NUM_READ_MASTERS-1:0] grant);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < NUM_READ_MASTERS; i++) begin
      if (grant[i]) begin
        idx = 2'(i);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/mem_read_arb_select.sv
// Combinational grant selection for the memory read arbiter. The search starts at
// pointer_i and wraps, so a pointer of 0 gives fixed dc > ic > sb priority.
module mem_read_arb_select
  import mem_read_arbiter_pkg::*;
(
  input  logic [NUM_READ_MASTERS-1:0] requests_i,
  input  logic [1:0]                  pointer_i,
  output logic [NUM_READ_MASTERS-1:0] grant_o
);

  logic       found;
  logic [2:0] slot;
  logic [1:0] idx;

  // Walk the requesters from the pointer onwards and grant the first one asking.
  always_comb begin
    grant_o = '0;
    found   = 1'b0;
    slot    = '0;
    idx     = '0;
    for (int i = 0; i < NUM_READ_MASTERS; i++) begin
      slot = {1'b0, pointer_i} + 3'(i);
      if (slot >= 3'(NUM_READ_MASTERS)) begin
        slot = slot - 3'(NUM_READ_MASTERS);
      end
      idx = slot[1:0];
      if (!found && requests_i[idx]) begin
        grant_o[idx] = 1'b1;
        found        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_read_arbiter.sv
// Memory read arbiter: shares one AXI-style read port between the D-cache (0),
// I-cache (1) and I-stream-buffer (2) refill requesters, one burst at a time.
// Optional feature: define MEM_ARB_ROUND_ROBIN_EN for round-robin arbitration;
// without it, fixed priority dc > ic > sb applies and no pointer register exists.
module mem_read_arbiter
  import mem_read_arbiter_pkg::*;
#(
  parameter int ARLEN_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   dc_arvalid_i,
  input  logic [ADDR_WIDTH-1:0]  dc_araddr_i,
  input  logic [ARLEN_WIDTH-1:0] dc_arlen_i,
  input  logic [ID_WIDTH-1:0]    dc_arid_i,
  output logic                   dc_arready_o,
  output logic                   dc_rvalid_o,
  output logic [DATA_WIDTH-1:0]  dc_rdata_o,
  input  logic                   dc_rready_i,
  input  logic                   ic_arvalid_i,
  input  logic [ADDR_WIDTH-1:0]  ic_araddr_i,
  input  logic [ARLEN_WIDTH-1:0] ic_arlen_i,
  input  logic [ID_WIDTH-1:0]    ic_arid_i,
  output logic                   ic_arready_o,
  output logic                   ic_rvalid_o,
  output logic [DATA_WIDTH-1:0]  ic_rdata_o,
  input  logic                   ic_rready_i,
  input  logic                   sb_arvalid_i,
  input  logic [ADDR_WIDTH-1:0]  sb_araddr_i,
  input  logic [ARLEN_WIDTH-1:0] sb_arlen_i,
  input  logic [ID_WIDTH-1:0]    sb_arid_i,
  output logic                   sb_arready_o,
  output logic                   sb_rvalid_o,
  output logic [DATA_WIDTH-1:0]  sb_rdata_o,
  input  logic                   sb_rready_i,
  output logic                   mem_arvalid_o,
  output logic [ADDR_WIDTH-1:0]  mem_araddr_o,
  output logic [ARLEN_WIDTH-1:0] mem_arlen_o,
  output logic [ID_WIDTH-1:0]    mem_arid_o,
  input  logic                   mem_arready_i,
  input  logic                   mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0]  mem_rdata_i,
  output logic                   mem_rready_o
);

  localparam int CNT_WIDTH = ARLEN_WIDTH + 1;

  logic [NUM_READ_MASTERS-1:0] reqVec;
  logic [NUM_READ_MASTERS-1:0] rreadyVec;
  logic [NUM_READ_MASTERS-1:0] grantOneHot;
  logic [NUM_READ_MASTERS-1:0] arreadyVec;
  logic [NUM_READ_MASTERS-1:0] rvalidVec;
  logic [NUM_READ_MASTERS-1:0] routeVec;
  logic [ADDR_WIDTH-1:0]       araddrArr [NUM_READ_MASTERS];
  logic [ARLEN_WIDTH-1:0]      arlenArr  [NUM_READ_MASTERS];
  logic [ID_WIDTH-1:0]         aridArr   [NUM_READ_MASTERS];
  logic [1:0]                  grantIdxNew;
  logic [1:0]                  selPtr;
  logic [CNT_WIDTH-1:0]        lastBeat;

  arb_state_e             state_q, state_d;
  logic [1:0]             grantIdx_q, grantIdx_d;
  logic [ADDR_WIDTH-1:0]  araddr_q, araddr_d;
  logic [ARLEN_WIDTH-1:0] arlen_q, arlen_d;
  logic [ID_WIDTH-1:0]    arid_q, arid_d;
  logic [CNT_WIDTH-1:0]   beatCnt_q, beatCnt_d;

  assign reqVec       = {sb_arvalid_i, ic_arvalid_i, dc_arvalid_i};
  assign rreadyVec    = {sb_rready_i, ic_rready_i, dc_rready_i};
  assign araddrArr[0] = dc_araddr_i;
  assign araddrArr[1] = ic_araddr_i;
  assign araddrArr[2] = sb_araddr_i;
  assign arlenArr[0]  = dc_arlen_i;
  assign arlenArr[1]  = ic_arlen_i;
  assign arlenArr[2]  = sb_arlen_i;
  assign aridArr[0]   = dc_arid_i;
  assign aridArr[1]   = ic_arid_i;
  assign aridArr[2]   = sb_arid_i;

  mem_read_arb_select u_select (
    .requests_i (reqVec),
    .pointer_i  (selPtr),
    .grant_o    (grantOneHot)
  );

  assign grantIdxNew = grant_to_index(grantOneHot);

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic [1:0] rrPtr_q, rrPtr_d;

  // Move the round-robin pointer just past whichever requester wins in IDLE.
  always_comb begin
    rrPtr_d = rrPtr_q;
    if (state_q == ARB_IDLE && |reqVec) begin
      rrPtr_d = (grantIdxNew == 2'd2) ? 2'd0 : grantIdxNew + 2'd1;
    end
  end

  // Round-robin pointer register, back to the D-cache on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rrPtr_q <= 2'd0;
    end else begin
      rrPtr_q <= rrPtr_d;
    end
  end

  assign selPtr = rrPtr_q;
`else
  assign selPtr = 2'd0;
`endif

  // A zero burst length still moves one beat, so its last beat index is 0.
  assign lastBeat = (arlen_q == '0) ? '0 : ({1'b0, arlen_q} - CNT_WIDTH'(1));

  // Next-state logic: latch a request in IDLE, hand it to memory in ADDR, count beats in DATA.
  always_comb begin
    state_d      = state_q;
    grantIdx_d   = grantIdx_q;
    araddr_d     = araddr_q;
    arlen_d      = arlen_q;
    arid_d       = arid_q;
    beatCnt_d    = beatCnt_q;
    arreadyVec   = '0;
    rvalidVec    = '0;
    routeVec     = '0;
    mem_arvalid_o = 1'b0;
    mem_rready_o  = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (|reqVec) begin
          grantIdx_d = grantIdxNew;
          araddr_d   = araddrArr[grantIdxNew];
          arlen_d    = arlenArr[grantIdxNew];
          arid_d     = aridArr[grantIdxNew];
          state_d    = ARB_ADDR;
        end
      end
      ARB_ADDR: begin
        mem_arvalid_o = 1'b1;
        if (mem_arready_i) begin
          arreadyVec[grantIdx_q] = 1'b1;
          beatCnt_d              = '0;
          state_d                = ARB_DATA;
        end
      end
      ARB_DATA: begin
        routeVec[grantIdx_q]  = 1'b1;
        rvalidVec[grantIdx_q] = mem_rvalid_i;
        mem_rready_o          = rreadyVec[grantIdx_q];
        if (mem_rvalid_i && rreadyVec[grantIdx_q]) begin
          if (beatCnt_q == lastBeat) begin
            state_d = ARB_IDLE;
          end else begin
            beatCnt_d = beatCnt_q + CNT_WIDTH'(1);
          end
        end
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  // Arbiter state, grant and latched request registers; reset abandons any burst.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ARB_IDLE;
      grantIdx_q <= 2'd0;
      araddr_q   <= '0;
      arlen_q    <= '0;
      arid_q     <= '0;
      beatCnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      grantIdx_q <= grantIdx_d;
      araddr_q   <= araddr_d;
      arlen_q    <= arlen_d;
      arid_q     <= arid_d;
      beatCnt_q  <= beatCnt_d;
    end
  end

  assign mem_araddr_o = araddr_q;
  assign mem_arlen_o  = arlen_q;
  assign mem_arid_o   = arid_q;

  assign dc_arready_o = arreadyVec[0];
  assign ic_arready_o = arreadyVec[1];
  assign sb_arready_o = arreadyVec[2];
  assign dc_rvalid_o  = rvalidVec[0];
  assign ic_rvalid_o  = rvalidVec[1];
  assign sb_rvalid_o  = rvalidVec[2];
  assign dc_rdata_o   = routeVec[0] ? mem_rdata_i : '0;
  assign ic_rdata_o   = routeVec[1] ? mem_rdata_i : '0;
  assign sb_rdata_o   = routeVec[2] ? mem_rdata_i : '0;

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Directed testbench for mem_read_arbiter: reset, fixed priority, stalled address
// handshake, gapped beats, reset mid-burst, single-beat bursts and grant order.
module tb_mem_read_arbiter;
  import mem_read_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        dc_arvalid, ic_arvalid, sb_arvalid;
  logic [31:0] dc_araddr, ic_araddr, sb_araddr;
  logic [3:0]  dc_arlen, ic_arlen, sb_arlen;
  logic [3:0]  dc_arid, ic_arid, sb_arid;
  logic        dc_arready, ic_arready, sb_arready;
  logic        dc_rvalid, ic_rvalid, sb_rvalid;
  logic [31:0] dc_rdata, ic_rdata, sb_rdata;
  logic        dc_rready, ic_rready, sb_rready;
  logic        mem_arvalid, mem_arready, mem_rvalid, mem_rready;
  logic [31:0] mem_araddr, mem_rdata;
  logic [3:0]  mem_arlen, mem_arid;

  int assertCount = 0;
  int failCount   = 0;

  mem_read_arbiter #(.ARLEN_WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .dc_arvalid_i(dc_arvalid), .dc_araddr_i(dc_araddr), .dc_arlen_i(dc_arlen), .dc_arid_i(dc_arid),
    .dc_arready_o(dc_arready), .dc_rvalid_o(dc_rvalid), .dc_rdata_o(dc_rdata), .dc_rready_i(dc_rready),
    .ic_arvalid_i(ic_arvalid), .ic_araddr_i(ic_araddr), .ic_arlen_i(ic_arlen), .ic_arid_i(ic_arid),
    .ic_arready_o(ic_arready), .ic_rvalid_o(ic_rvalid), .ic_rdata_o(ic_rdata), .ic_rready_i(ic_rready),
    .sb_arvalid_i(sb_arvalid), .sb_araddr_i(sb_araddr), .sb_arlen_i(sb_arlen), .sb_arid_i(sb_arid),
    .sb_arready_o(sb_arready), .sb_rvalid_o(sb_rvalid), .sb_rdata_o(sb_rdata), .sb_rready_i(sb_rready),
    .mem_arvalid_o(mem_arvalid), .mem_araddr_o(mem_araddr), .mem_arlen_o(mem_arlen), .mem_arid_o(mem_arid),
    .mem_arready_i(mem_arready), .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata), .mem_rready_o(mem_rready)
  );

  // Free-running 10-unit clock.
  initial begin
    forever #5 clk = ~clk;
  end

  // Guard against a stuck run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic clearInputs();
    dc_arvalid = 0; dc_araddr = '0; dc_arlen = '0; dc_arid = '0; dc_rready = 0;
    ic_arvalid = 0; ic_araddr = '0; ic_arlen = '0; ic_arid = '0; ic_rready = 0;
    sb_arvalid = 0; sb_araddr = '0; sb_arlen = '0; sb_arid = '0; sb_rready = 0;
    mem_arready = 0; mem_rvalid = 0; mem_rdata = '0;
  endtask

  task automatic nextDrive();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clearInputs();
    #2 rst_n = 0;
    dc_arvalid = 1; dc_rready = 1; mem_arready = 1; mem_rvalid = 1; mem_rdata = 32'hDEAD_BEEF;
    repeat (2) @(negedge clk);
    assertCount++;
    if (mem_arvalid !== 1'b0) begin failCount++; $display("[TB] FAIL reset_mem_arvalid actual=%0b required=0", mem_arvalid); end
    assertCount++;
    if ({dc_arready, ic_arready, sb_arready} !== 3'b000) begin failCount++; $display("[TB] FAIL reset_arready actual=%b required=000", {dc_arready, ic_arready, sb_arready}); end
    assertCount++;
    if ({dc_rvalid, mem_rready, dc_rdata} !== 34'd0) begin failCount++; $display("[TB] FAIL reset_rchan actual=%b/%b/%h required=0/0/0", dc_rvalid, mem_rready, dc_rdata); end
    @(negedge clk);
    clearInputs();
    rst_n = 1;
    repeat (2) @(negedge clk);
    assertCount++;
    if (mem_arvalid !== 1'b0) begin failCount++; $display("[TB] FAIL idle_hold_arvalid actual=%0b required=0", mem_arvalid); end
  endtask

  task automatic test_fixed_priority();
    nextDrive();
    dc_arvalid = 1; dc_araddr = 32'h0000_2000; dc_arlen = 4; dc_arid = ARID_DC; dc_rready = 1;
    sb_arvalid = 1; sb_araddr = 32'h0000_8080; sb_arlen = 4; sb_arid = ARID_SB; sb_rready = 1;
    mem_arready = 1;
    @(posedge clk);
    @(negedge clk);
    assertCount++;
    if ({mem_arvalid, mem_araddr, mem_arid, mem_arlen} !== {1'b1, 32'h0000_2000, ARID_DC, 4'd4}) begin
      failCount++; $display("[TB] FAIL fp_dc_addr actual=%0b/%h/%0d/%0d required=1/00002000/1/4", mem_arvalid, mem_araddr, mem_arid, mem_arlen);
    end
    assertCount++;
    if ({dc_arready, ic_arready, sb_arready} !== 3'b100) begin failCount++; $display("[TB] FAIL fp_dc_arready actual=%b required=100", {dc_arready, ic_arready, sb_arready}); end
    nextDrive();
    dc_arvalid = 0;
    for (int b = 0; b < 4; b++) begin
      mem_rvalid = 1; mem_rdata = 32'hD000_0000 + b;
      @(negedge clk);
      assertCount++;
      if ({dc_rvalid, dc_rdata, mem_rready} !== {1'b1, 32'hD000_0000 + b, 1'b1}) begin
        failCount++; $display("[TB] FAIL fp_dc_beat%0d actual=%0b/%h/%0b required=1/%h/1", b, dc_rvalid, dc_rdata, mem_rready, 32'hD000_0000 + b);
      end
      assertCount++;
      if ({sb_rvalid, sb_rdata, ic_rvalid, ic_rdata} !== 66'd0) begin failCount++; $display("[TB] FAIL fp_sb_isolated%0d actual=%0b/%h required=0/0", b, sb_rvalid, sb_rdata); end
      nextDrive();
    end
    mem_rvalid = 0;
    @(negedge clk);
    assertCount++;
    if ({mem_arvalid, mem_rready, sb_arready} !== 3'b000) begin failCount++; $display("[TB] FAIL fp_idle_after_burst actual=%b required=000", {mem_arvalid, mem_rready, sb_arready}); end
    @(negedge clk);
    assertCount++;
    if ({mem_arvalid, mem_araddr, mem_arid} !== {1'b1, 32'h0000_8080, ARID_SB}) begin
      failCount++; $display("[TB] FAIL fp_sb_addr actual=%0b/%h/%0d required=1/00008080/2", mem_arvalid, mem_araddr, mem_arid);
    end
    assertCount++;
    if ({dc_arready, ic_arready, sb_arready} !== 3'b001) begin failCount++; $display("[TB] FAIL fp_sb_arready actual=%b required=001", {dc_arready, ic_arready, sb_arready}); end
    nextDrive();
    sb_arvalid = 0; mem_arready = 0;
    for (int b = 0; b < 4; b++) begin
      mem_rvalid = 1; mem_rdata = 32'h5B00_0000 + b;
      @(negedge clk);
      assertCount++;
      if ({sb_rvalid, sb_rdata, dc_rvalid} !== {1'b1, 32'h5B00_0000 + b, 1'b0}) begin
        failCount++; $display("[TB] FAIL fp_sb_beat%0d actual=%0b/%h/%0b required=1/%h/0", b, sb_rvalid, sb_rdata, dc_rvalid, 32'h5B00_0000 + b);
      end
      nextDrive();
    end
    clearInputs();
  endtask

  task automatic test_ic_delayed_gapped();
    logic [6:0] beatOn;
    int         pulses;
    beatOn = 7'b1001101;
    pulses = 0;
    nextDrive();
    ic_arvalid = 1; ic_araddr = 32'h0000_1040; ic_arlen = 4; ic_arid = ARID_IC; ic_rready = 1;
    mem_arready = 0;
    @(posedge clk);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (ic_arready) pulses++;
      assertCount++;
      if ({mem_arvalid, mem_araddr, mem_arlen, mem_arid} !== {1'b1, 32'h0000_1040, 4'd4, ARID_IC}) begin
        failCount++; $display("[TB] FAIL ic_stall%0d actual=%0b/%h/%0d required=1/00001040/4", c, mem_arvalid, mem_araddr, mem_arlen);
      end
    end
    nextDrive();
    mem_arready = 1;
    @(negedge clk);
    if (ic_arready) pulses++;
    assertCount++;
    if ({mem_arvalid, mem_araddr} !== {1'b1, 32'h0000_1040}) begin failCount++; $display("[TB] FAIL ic_handshake actual=%0b/%h required=1/00001040", mem_arvalid, mem_araddr); end
    nextDrive();
    ic_arvalid = 0; mem_arready = 0;
    for (int c = 1; c <= 8; c++) begin
      mem_rvalid = (c == 8) ? 1'b1 : beatOn[c-1];
      mem_rdata  = 32'hC0DE_0000 + c;
      if (c == 7) begin
        ic_arvalid = 1; ic_araddr = 32'h0000_1080; ic_arlen = 4;
      end
      @(negedge clk);
      if (ic_arready) pulses++;
      if (c <= 7) begin
        assertCount++;
        if ({ic_rvalid, mem_rready} !== {beatOn[c-1], 1'b1}) begin
          failCount++; $display("[TB] FAIL gap_cycle%0d actual=%0b/%0b required=%0b/1", c, ic_rvalid, mem_rready, beatOn[c-1]);
        end
      end else begin
        assertCount++;
        if ({ic_rvalid, mem_rready, mem_arvalid} !== 3'b000) begin
          failCount++; $display("[TB] FAIL gap_idle_cycle8 actual=%b required=000", {ic_rvalid, mem_rready, mem_arvalid});
        end
      end
      if (c == 7) begin
        assertCount++;
        if ({mem_arvalid, ic_arready} !== 2'b00) begin failCount++; $display("[TB] FAIL gap_no_grant_last actual=%b required=00", {mem_arvalid, ic_arready}); end
      end
      nextDrive();
    end
    assertCount++;
    if (pulses !== 1) begin failCount++; $display("[TB] FAIL ic_arready_pulses actual=%0d required=1", pulses); end
    mem_rvalid = 0; mem_arready = 1;
    @(negedge clk);
    assertCount++;
    if ({mem_arvalid, mem_araddr} !== {1'b1, 32'h0000_1080}) begin failCount++; $display("[TB] FAIL gap_next_grant actual=%0b/%h required=1/00001080", mem_arvalid, mem_araddr); end
    nextDrive();
    ic_arvalid = 0; mem_arready = 0; mem_rvalid = 1;
    repeat (4) @(posedge clk);
    #1;
    clearInputs();
  endtask

  task automatic test_reset_mid_burst();
    nextDrive();
    sb_arvalid = 1; sb_araddr = 32'h0000_3300; sb_arlen = 4; sb_arid = ARID_SB; sb_rready = 1;
    mem_arready = 1;
    @(posedge clk);
    nextDrive();
    sb_arvalid = 0; mem_arready = 0; mem_rvalid = 1; mem_rdata = 32'hABCD_0001;
    @(negedge clk);
    nextDrive();
    mem_rdata = 32'hABCD_0002;
    @(negedge clk);
    assertCount++;
    if ({sb_rvalid, sb_rdata} !== {1'b1, 32'hABCD_0002}) begin failCount++; $display("[TB] FAIL rst_beat2 actual=%0b/%h required=1/abcd0002", sb_rvalid, sb_rdata); end
    nextDrive();
    mem_rdata = 32'hABCD_0003;
    #1 rst_n = 0;
    #1;
    assertCount++;
    if ({sb_rvalid, sb_rdata, mem_rready, mem_arvalid, sb_arready} !== 36'd0) begin
      failCount++; $display("[TB] FAIL rst_async_outputs actual=%0b/%h/%0b/%0b required=0/0/0/0", sb_rvalid, sb_rdata, mem_rready, mem_arvalid);
    end
    @(negedge clk);
    rst_n = 1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      assertCount++;
      if ({sb_rvalid, mem_rready} !== 2'b00) begin failCount++; $display("[TB] FAIL rst_post_release%0d actual=%b required=00", c, {sb_rvalid, mem_rready}); end
    end
    clearInputs();
  endtask

  task automatic test_arlen_zero();
    int beatsSeen;
    beatsSeen = 0;
    nextDrive();
    dc_arvalid = 1; dc_araddr = 32'h0000_4400; dc_arlen = 0; dc_arid = ARID_DC; dc_rready = 1;
    mem_arready = 1;
    @(posedge clk);
    @(negedge clk);
    assertCount++;
    if ({mem_arvalid, mem_arlen, dc_arready} !== {1'b1, 4'd0, 1'b1}) begin failCount++; $display("[TB] FAIL z_addr actual=%0b/%0d/%0b required=1/0/1", mem_arvalid, mem_arlen, dc_arready); end
    nextDrive();
    dc_arvalid = 0; mem_arready = 0; mem_rvalid = 1; mem_rdata = 32'h5A5A_0001;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (dc_rvalid) beatsSeen++;
      if (c > 0) begin
        assertCount++;
        if (mem_rready !== 1'b0) begin failCount++; $display("[TB] FAIL z_idle_rready%0d actual=%0b required=0", c, mem_rready); end
      end
      nextDrive();
    end
    assertCount++;
    if (beatsSeen !== 1) begin failCount++; $display("[TB] FAIL z_beat_count actual=%0d required=1", beatsSeen); end
    clearInputs();
  endtask

  task automatic test_grant_order();
    logic [1:0] expOrder [4];
    logic [1:0] got;
    int         grantsSeen;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    expOrder = '{2'd0, 2'd1, 2'd2, 2'd0};
`else
    expOrder = '{2'd0, 2'd0, 2'd0, 2'd0};
`endif
    grantsSeen = 0;
    nextDrive();
    dc_arvalid = 1; dc_araddr = 32'h0000_A000; dc_arid = ARID_DC; dc_rready = 1;
    ic_arvalid = 1; ic_araddr = 32'h0000_B000; ic_arid = ARID_IC; ic_rready = 1;
    sb_arvalid = 1; sb_araddr = 32'h0000_C000; sb_arid = ARID_SB; sb_rready = 1;
    mem_arready = 1; mem_rvalid = 1;
    for (int c = 0; c < 13; c++) begin
      @(negedge clk);
      if (dc_arready || ic_arready || sb_arready) begin
        case ({sb_arready, ic_arready, dc_arready})
          3'b001:  got = 2'd0;
          3'b010:  got = 2'd1;
          3'b100:  got = 2'd2;
          default: got = 2'd3;
        endcase
        if (grantsSeen < 4) begin
          assertCount++;
          if (got !== expOrder[grantsSeen]) begin failCount++; $display("[TB] FAIL order_grant%0d actual=%0d required=%0d", grantsSeen, got, expOrder[grantsSeen]); end
        end
        grantsSeen++;
      end
    end
    clearInputs();
    assertCount++;
    if (grantsSeen !== 4) begin failCount++; $display("[TB] FAIL order_grant_count actual=%0d required=4", grantsSeen); end
    repeat (2) @(negedge clk);
  endtask

  // Run every scenario in order, then report.
  initial begin
    test_reset();
    test_fixed_priority();
    test_ic_delayed_gapped();
    test_reset_mid_burst();
    test_arlen_zero();
    test_grant_order();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
